// File: rtl/output_port_arbiter_pkg.sv
// Shared types and constants for the mesh-router output port.
// Holds port indices, DIRECTION one-hot codes, flit field positions, the flit
// payload struct, the buffer state enum and the round-robin pointer helper.
package output_port_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned NUM_IN     = 5;
  localparam int unsigned PTR_W      = 3;

  // Input port indices; bit position matches the DIRECTION one-hot code.
  localparam int unsigned PORT_L  = 0;
  localparam int unsigned PORT_R  = 1;
  localparam int unsigned PORT_U  = 2;
  localparam int unsigned PORT_D  = 3;
  localparam int unsigned PORT_PE = 4;

  localparam logic [NUM_IN-1:0] DIR_L  = 5'b00001;
  localparam logic [NUM_IN-1:0] DIR_R  = 5'b00010;
  localparam logic [NUM_IN-1:0] DIR_U  = 5'b00100;
  localparam logic [NUM_IN-1:0] DIR_D  = 5'b01000;
  localparam logic [NUM_IN-1:0] DIR_PE = 5'b10000;

  // Flit field positions.
  localparam int unsigned DIR_X_BIT    = 62;
  localparam int unsigned DIR_Y_BIT    = 61;
  localparam int unsigned HOP_X_MSB    = 55;
  localparam int unsigned HOP_X_LSB    = 52;
  localparam int unsigned HOP_Y_MSB    = 51;
  localparam int unsigned HOP_Y_LSB    = 48;
  localparam int unsigned SOURCE_X_MSB = 47;
  localparam int unsigned SOURCE_X_LSB = 40;
  localparam int unsigned SOURCE_Y_MSB = 39;
  localparam int unsigned SOURCE_Y_LSB = 32;

  typedef struct packed {
    logic        spare;
    logic        dir_x;
    logic        dir_y;
    logic [4:0]  rsvd;
    logic [3:0]  hop_x;
    logic [3:0]  hop_y;
    logic [7:0]  source_x;
    logic [7:0]  source_y;
    logic [31:0] payload;
  } flit_t;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

  // Round-robin pointer successor with wrap at NUM_IN.
  function automatic ptr_t ptr_inc(input ptr_t idx);
    return (idx == ptr_t'(NUM_IN - 1)) ? '0 : idx + ptr_t'(1);
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Link-side bundle of the output port arbiter.
//   reqIn    : per-input request toward this output
//   dataIn   : flat per-input flits, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   gntOut   : one-hot combinational grant back to the winning input
//   dataOut  : registered flit toward the link
//   validOut : dataOut holds a valid flit
//   readyIn  : link accepts the flit this cycle
// slave = arbiter side, master = routing units + link side.
interface output_port_arbiter_if;
  import output_port_arbiter_pkg::*;

  logic [NUM_IN-1:0]            reqIn;
  logic [NUM_IN*DATA_WIDTH-1:0] dataIn;
  logic [NUM_IN-1:0]            gntOut;
  flit_t                        dataOut;
  logic                         validOut;
  logic                         readyIn;

  modport master (
    output reqIn, dataIn, readyIn,
    input  gntOut, dataOut, validOut
  );

  modport slave (
    input  reqIn, dataIn, readyIn,
    output gntOut, dataOut, validOut
  );

endinterface

// File: rtl/output_port_arbiter_rr.sv
// Five-way round-robin arbiter (rr_arbiter5), purely combinational.
//   req    : request vector
//   enable : grant permitted this cycle
//   ptr    : highest-priority index for this cycle
//   gnt    : one-hot grant (zero when disabled or no request)
//   winner : encoded index of the first requester at or after ptr
//   hit    : a grant is issued
module output_port_arbiter_rr
  import output_port_arbiter_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic              enable,
  input  ptr_t              ptr,
  output logic [NUM_IN-1:0] gnt,
  output ptr_t              winner,
  output logic              hit
);

  ptr_t idx;
  logic found;

  // Scan ptr, ptr+1, ... modulo NUM_IN; first set request wins.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    gnt    = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = ptr_t'((32'(ptr) + k) % NUM_IN);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    hit = found & enable;
    if (hit) begin
      gnt[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Output stage of one mesh-router port: round-robin selection among five
// routing units, single-entry output buffer, valid/ready link handshake.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : link bundle (slave side), see output_port_arbiter_if
module output_port_arbiter
  import output_port_arbiter_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  output_port_arbiter_if.slave bus
);

  buf_state_t        state, state_next;
  flit_t             data_q, data_next;
  ptr_t              ptr_q, ptr_next;
  logic              can_accept;
  logic              grant_hit;
  logic [NUM_IN-1:0] gnt;
  ptr_t              winner;
  flit_t             sel_flit;

  // Buffer can take a flit when empty or when it drains on this same edge.
  assign can_accept = (state == ST_EMPTY) || ((state == ST_FULL) && bus.readyIn);

  output_port_arbiter_rr u_rr (
    .req    (bus.reqIn),
    .enable (can_accept && !reset),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .winner (winner),
    .hit    (grant_hit)
  );

  // Select the winning input's flit slice.
  always_comb begin
    sel_flit = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (winner == ptr_t'(i)) begin
        sel_flit = bus.dataIn[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State, buffer and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_EMPTY;
      data_q <= '0;
      ptr_q  <= '0;
    end else begin
      state  <= state_next;
      data_q <= data_next;
      ptr_q  <= ptr_next;
    end
  end

  // Next buffer state: refill wins over drain, so drain+refill stays FULL.
  always_comb begin
    state_next = state;
    if (grant_hit) begin
      state_next = ST_FULL;
    end else if ((state == ST_FULL) && bus.readyIn) begin
      state_next = ST_EMPTY;
    end
  end

  // Buffer contents and pointer update; both hold unless a grant is issued.
  always_comb begin
    data_next = data_q;
    ptr_next  = ptr_q;
    if (grant_hit) begin
      data_next = sel_flit;
      ptr_next  = ptr_inc(winner);
    end
  end

  assign bus.gntOut   = gnt;
  assign bus.validOut = (state == ST_FULL);
  assign bus.dataOut  = data_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural buffer/arbiter model.
module tb_output_port_arbiter;
  import output_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_port_arbiter_if bus ();

  output_port_arbiter dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffer occupancy, buffered flit, next priority index.
  bit          m_full;
  logic [63:0] m_data;
  int          m_ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_gnt(input logic [4:0] req, input logic ready);
    int idx;
    if (m_full && !ready) return 5'b0;
    for (int k = 0; k < 5; k++) begin
      idx = (m_ptr + k) % 5;
      if (req[idx]) return 5'(1) << idx;
    end
    return 5'b0;
  endfunction

  task automatic set_slice(input int i, input logic [63:0] v);
    bus.dataIn[i*64 +: 64] = v;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 5; i++) set_slice(i, {$urandom, $urandom});
  endtask

  // One clock cycle: drive at posedge+1, check grant before next edge,
  // check registered outputs at following posedge+1.
  task automatic cycle(input logic [4:0] req, input logic ready);
    logic [4:0] eg;
    int w;
    bus.reqIn   = req;
    bus.readyIn = ready;
    #3;
    eg = model_gnt(req, ready);
    check("gnt", 64'(bus.gntOut), 64'(eg));
    if (eg != 5'b0) begin
      w = 0;
      for (int i = 0; i < 5; i++) if (eg[i]) w = i;
      m_data = bus.dataIn[w*64 +: 64];
      m_full = 1'b1;
      m_ptr  = (w + 1) % 5;
    end else if (m_full && ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    check("valid", 64'(bus.validOut), 64'(m_full));
    check("data", bus.dataOut, m_data);
  endtask

  // Asynchronous reset pulse with requests pending; outputs must clear at once.
  task automatic do_reset();
    bus.reqIn   = 5'b11111;
    bus.readyIn = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(bus.validOut), 64'd0);
    check("rst_data", bus.dataOut, 64'd0);
    check("rst_gnt", 64'(bus.gntOut), 64'd0);
    m_full = 1'b0;
    m_data = '0;
    m_ptr  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.reqIn   = '0;
    bus.readyIn = 1'b0;
    bus.dataIn  = '0;
    m_full = 1'b0;
    m_data = '0;
    m_ptr  = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single request from input 2.
    randomize_data();
    set_slice(2, 64'hA5);
    cycle(5'b00100, 1'b1);
    check("single_data", bus.dataOut, 64'hA5);
    // Pointer now 3: full request set must pick input 3.
    cycle(5'b11111, 1'b1);
    check("ptr_after_single", 64'(m_ptr), 64'd4);

    // All inputs requesting from ptr=0, link always ready.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      randomize_data();
      cycle(5'b11111, 1'b1);
      check("all_req_valid", 64'(bus.validOut), 64'd1);
    end

    // Backpressure while full, then release with same-cycle refill.
    randomize_data();
    for (int n = 0; n < 3; n++) cycle(5'b00011, 1'b0);
    cycle(5'b00011, 1'b1);
    check("bp_release_valid", 64'(bus.validOut), 64'd1);

    // Pointer wrap from 4 to 0.
    do_reset();
    randomize_data();
    cycle(5'b01000, 1'b1);
    cycle(5'b10001, 1'b1);
    cycle(5'b10001, 1'b1);

    // Drain to empty, pointer unchanged.
    cycle(5'b00000, 1'b1);
    cycle(5'b00000, 1'b1);
    cycle(5'b00110, 1'b1);

    // Reset while full, then first grant scans from index 0.
    randomize_data();
    cycle(5'b00100, 1'b0);
    cycle(5'b00000, 1'b0);
    do_reset();
    randomize_data();
    cycle(5'b01100, 1'b1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      randomize_data();
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
